// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the shared external memory port.
// Requester 0 is the icache refill path (read only). Requester 1 is the
// dcache path (block read or single-word write). One whole transaction is
// granted at a time. Memory requests are sequenced, refill beats are counted
// and read data is routed back to the owner.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   R0_*                  icache side: REQ/ADDR in; GNT/RVALID/RDATA/BEAT/DONE out
//   R1_*                  dcache side: REQ/WE/ADDR/WDATA in; same outputs as R0
//   MEM_*                 memory side: READ_REQ/WRITE_REQ/ADDRESS/WRITEDATA out;
//                         BUSYWAIT/READDATA/READDATA_VALID in
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEATS      = 4,
    localparam int BW        = $clog2(BEATS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  R0_REQ,
    input  logic [ADDR_WIDTH-1:0] R0_ADDR,
    output logic                  R0_GNT,
    output logic                  R0_RVALID,
    output logic [DATA_WIDTH-1:0] R0_RDATA,
    output logic [BW-1:0]         R0_BEAT,
    output logic                  R0_DONE,
    input  logic                  R1_REQ,
    input  logic                  R1_WE,
    input  logic [ADDR_WIDTH-1:0] R1_ADDR,
    input  logic [DATA_WIDTH-1:0] R1_WDATA,
    output logic                  R1_GNT,
    output logic                  R1_RVALID,
    output logic [DATA_WIDTH-1:0] R1_RDATA,
    output logic [BW-1:0]         R1_BEAT,
    output logic                  R1_DONE,
    output logic                  MEM_READ_REQ,
    output logic                  MEM_WRITE_REQ,
    output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
    output logic [DATA_WIDTH-1:0] MEM_WRITEDATA,
    input  logic                  MEM_BUSYWAIT,
    input  logic [DATA_WIDTH-1:0] MEM_READDATA,
    input  logic                  MEM_READDATA_VALID
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    // Block reads are aligned to a BEATS-word boundary.
    localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ~ADDR_WIDTH'(BEATS - 1);

    state_t                  state;
    state_t                  state_n;
    logic                    owner;
    logic                    last_grant;
    logic [BW-1:0]           beat_cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    we_q;
    logic                    take;
    logic                    sel;
    logic                    accept;
    logic                    beat_in;
    logic                    busy_own;
    logic                    rd_phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
        end else begin
            state <= state_n;
            if (take) begin
                owner   <= sel;
                addr_q  <= sel ? R1_ADDR : R0_ADDR;
                wdata_q <= sel ? R1_WDATA : '0;
                we_q    <= sel & R1_WE;
            end
            if (accept) begin
                beat_cnt <= '0;
            end else if (beat_in) begin
                // Power-of-two BEATS: the last beat wraps the counter to 0.
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (state == DONE) begin
                last_grant <= owner;
            end
        end
    end

    always_comb begin
        state_n = state;
        take    = 1'b0;
        accept  = 1'b0;
        beat_in = 1'b0;
        // A lone requester wins; on a tie the one not served last wins.
        sel     = (R0_REQ && R1_REQ) ? ~last_grant : R1_REQ;
        unique case (state)
            IDLE: begin
                if (R0_REQ || R1_REQ) begin
                    take    = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (!MEM_BUSYWAIT) begin
                    accept  = 1'b1;
                    state_n = we_q ? DONE : RDATA;
                end
            end
            RDATA: begin
                if (MEM_READDATA_VALID) begin
                    beat_in = 1'b1;
                    if (beat_cnt == LAST_BEAT) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy_own = (state != IDLE);
    assign rd_phase = (state == RDATA);

    assign R0_GNT    = busy_own & ~owner;
    assign R1_GNT    = busy_own & owner;
    assign R0_DONE   = (state == DONE) & ~owner;
    assign R1_DONE   = (state == DONE) & owner;
    assign R0_RVALID = rd_phase & ~owner & MEM_READDATA_VALID;
    assign R1_RVALID = rd_phase & owner & MEM_READDATA_VALID;
    assign R0_RDATA  = R0_RVALID ? MEM_READDATA : '0;
    assign R1_RDATA  = R1_RVALID ? MEM_READDATA : '0;
    assign R0_BEAT   = (rd_phase & ~owner) ? beat_cnt : '0;
    assign R1_BEAT   = (rd_phase & owner) ? beat_cnt : '0;

    assign MEM_READ_REQ  = (state == ISSUE) & ~we_q;
    assign MEM_WRITE_REQ = (state == ISSUE) & we_q;
    assign MEM_ADDRESS   = (state != ISSUE) ? '0 :
                           we_q ? addr_q : (addr_q & BLK_MASK);
    assign MEM_WRITEDATA = MEM_WRITE_REQ ? wdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Read beats and DONE pulses are checked against a scoreboard queue.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        R0_REQ = 1'b0;
    logic [31:0] R0_ADDR = '0;
    logic        R0_GNT, R0_RVALID, R0_DONE;
    logic [31:0] R0_RDATA;
    logic [1:0]  R0_BEAT;
    logic        R1_REQ = 1'b0;
    logic        R1_WE = 1'b0;
    logic [31:0] R1_ADDR = '0;
    logic [31:0] R1_WDATA = '0;
    logic        R1_GNT, R1_RVALID, R1_DONE;
    logic [31:0] R1_RDATA;
    logic [1:0]  R1_BEAT;
    logic        MEM_READ_REQ, MEM_WRITE_REQ;
    logic [31:0] MEM_ADDRESS, MEM_WRITEDATA;
    logic        MEM_BUSYWAIT = 1'b0;
    logic [31:0] MEM_READDATA = '0;
    logic        MEM_READDATA_VALID = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .BEATS(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .R0_REQ(R0_REQ),
        .R0_ADDR(R0_ADDR),
        .R0_GNT(R0_GNT),
        .R0_RVALID(R0_RVALID),
        .R0_RDATA(R0_RDATA),
        .R0_BEAT(R0_BEAT),
        .R0_DONE(R0_DONE),
        .R1_REQ(R1_REQ),
        .R1_WE(R1_WE),
        .R1_ADDR(R1_ADDR),
        .R1_WDATA(R1_WDATA),
        .R1_GNT(R1_GNT),
        .R1_RVALID(R1_RVALID),
        .R1_RDATA(R1_RDATA),
        .R1_BEAT(R1_BEAT),
        .R1_DONE(R1_DONE),
        .MEM_READ_REQ(MEM_READ_REQ),
        .MEM_WRITE_REQ(MEM_WRITE_REQ),
        .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT),
        .MEM_READDATA(MEM_READDATA),
        .MEM_READDATA_VALID(MEM_READDATA_VALID)
    );

    typedef struct {
        logic        own;
        logic [1:0]  beat;
        logic [31:0] data;
    } beat_t;

    beat_t sb[$];
    logic  dq[$];
    beat_t e;
    logic  d;
    int    tests = 0;
    int    fails = 0;

    wire any_out = |{R0_GNT, R0_RVALID, R0_RDATA, R0_BEAT, R0_DONE,
                     R1_GNT, R1_RVALID, R1_RDATA, R1_BEAT, R1_DONE,
                     MEM_READ_REQ, MEM_WRITE_REQ, MEM_ADDRESS, MEM_WRITEDATA};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Beat and DONE monitor: every forwarded beat / DONE pulse must match
    // the next scoreboard entry; anything unexpected is a failure.
    always @(negedge clk) begin
        if (R0_RVALID || R1_RVALID) begin
            if (sb.size() == 0) begin
                chk("stray_rvalid", {30'd0, R1_RVALID, R0_RVALID}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rv_owner", {30'd0, R1_RVALID, R0_RVALID},
                    e.own ? 32'd2 : 32'd1);
                chk("rdata", e.own ? R1_RDATA : R0_RDATA, e.data);
                chk("beat", {30'd0, e.own ? R1_BEAT : R0_BEAT},
                    {30'd0, e.beat});
            end
        end
        if (R0_DONE || R1_DONE) begin
            if (dq.size() == 0) begin
                chk("stray_done", {30'd0, R1_DONE, R0_DONE}, 32'd0);
            end else begin
                d = dq.pop_front();
                chk("done_owner", {30'd0, R1_DONE, R0_DONE},
                    d ? 32'd2 : 32'd1);
            end
        end
    end

    // Entered at the start of an IDLE cycle with the request(s) already up.
    task automatic run_txn(input logic own, input logic wr,
                           input logic [31:0] ea, input logic [31:0] wd,
                           input int busy, input int g0, input int g1,
                           input int g2, input int g3,
                           input logic [31:0] base, input bit chg);
        int gaps[4];
        logic [31:0] dv;
        gaps = '{g0, g1, g2, g3};
        smp();
        chk("idle_gnt", {30'd0, R1_GNT, R0_GNT}, 32'd0);
        chk("idle_req", {30'd0, MEM_WRITE_REQ, MEM_READ_REQ}, 32'd0);
        nxt();
        for (int i = 0; i <= busy; i++) begin
            MEM_BUSYWAIT = (i < busy);
            if (chg && i == 1) begin
                R0_ADDR = 32'h777;
                R1_ADDR = 32'h777;
            end
            smp();
            chk("issue_gnt", {30'd0, R1_GNT, R0_GNT}, own ? 32'd2 : 32'd1);
            chk("issue_req", {30'd0, MEM_WRITE_REQ, MEM_READ_REQ},
                wr ? 32'd2 : 32'd1);
            chk("mem_addr", MEM_ADDRESS, ea);
            chk("mem_wdata", MEM_WRITEDATA, wr ? wd : 32'd0);
            nxt();
        end
        MEM_BUSYWAIT = 1'b0;
        if (!wr) begin
            for (int b = 0; b < 4; b++) begin
                for (int g = 0; g < gaps[b]; g++) begin
                    MEM_READDATA_VALID = 1'b0;
                    smp();
                    chk("gap_req", {30'd0, MEM_WRITE_REQ, MEM_READ_REQ}, 32'd0);
                    chk("gap_gnt", {30'd0, R1_GNT, R0_GNT},
                        own ? 32'd2 : 32'd1);
                    nxt();
                end
                dv = base + 32'(b);
                MEM_READDATA_VALID = 1'b1;
                MEM_READDATA = dv;
                sb.push_back('{own, 2'(b), dv});
                smp();
                chk("rd_req", {30'd0, MEM_WRITE_REQ, MEM_READ_REQ}, 32'd0);
                nxt();
            end
            MEM_READDATA_VALID = 1'b0;
            MEM_READDATA = '0;
        end
        dq.push_back(own);
        if (own) R1_REQ = 1'b0;
        else R0_REQ = 1'b0;
        smp();
        chk("done_gnt", {30'd0, R1_GNT, R0_GNT}, own ? 32'd2 : 32'd1);
        nxt();
        chk("done_seen", dq.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        smp();
        chk("reset_outs", {31'd0, any_out}, 32'd0);
        nxt();
        reset = 1'b0;
        smp();
        chk("post_reset_outs", {31'd0, any_out}, 32'd0);
        nxt();

        // R0 block read with two busywait cycles.
        R0_ADDR = 32'h105;
        R0_REQ = 1'b1;
        run_txn(1'b0, 1'b0, 32'h104, 32'h0, 2, 0, 0, 0, 0, 32'hA0, 1'b0);

        // R1 single-word write.
        R1_WE = 1'b1;
        R1_ADDR = 32'h40;
        R1_WDATA = 32'hDEADBEEF;
        R1_REQ = 1'b1;
        run_txn(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h0, 1'b0);
        R1_WE = 1'b0;
        R1_WDATA = '0;

        // Fresh reset, then simultaneous requests and alternation.
        reset = 1'b1;
        smp();
        chk("reset2_outs", {31'd0, any_out}, 32'd0);
        nxt();
        reset = 1'b0;
        R0_ADDR = 32'h10;
        R1_ADDR = 32'h21;
        R0_REQ = 1'b1;
        R1_REQ = 1'b1;
        run_txn(1'b0, 1'b0, 32'h10, 32'h0, 0, 0, 0, 0, 0, 32'h100, 1'b0);
        R0_REQ = 1'b1;
        run_txn(1'b1, 1'b0, 32'h20, 32'h0, 1, 0, 0, 0, 0, 32'h110, 1'b0);
        R1_REQ = 1'b1;
        run_txn(1'b0, 1'b0, 32'h10, 32'h0, 0, 0, 0, 0, 0, 32'h120, 1'b0);
        run_txn(1'b1, 1'b0, 32'h20, 32'h0, 0, 0, 0, 0, 0, 32'h130, 1'b0);

        // Stray valid in IDLE, then a read with gaps (beats on 1,4,5,9).
        MEM_READDATA_VALID = 1'b1;
        MEM_READDATA = 32'hBAD;
        smp();
        chk("stray_idle_rv", {30'd0, R1_RVALID, R0_RVALID}, 32'd0);
        chk("stray_idle_rd", R0_RDATA | R1_RDATA, 32'd0);
        nxt();
        MEM_READDATA_VALID = 1'b0;
        MEM_READDATA = '0;
        R0_ADDR = 32'h80;
        R0_REQ = 1'b1;
        run_txn(1'b0, 1'b0, 32'h80, 32'h0, 0, 0, 2, 0, 3, 32'hF0, 1'b0);

        // Reset during RDATA after beat 1.
        R0_ADDR = 32'h300;
        R0_REQ = 1'b1;
        smp();
        nxt();
        smp();
        chk("abort_issue", {30'd0, MEM_WRITE_REQ, MEM_READ_REQ}, 32'd1);
        nxt();
        for (int b = 0; b < 2; b++) begin
            MEM_READDATA_VALID = 1'b1;
            MEM_READDATA = 32'hC0 + 32'(b);
            sb.push_back('{1'b0, 2'(b), 32'hC0 + 32'(b)});
            smp();
            nxt();
        end
        reset = 1'b1;
        R0_REQ = 1'b0;
        MEM_READDATA = 32'hC2;
        smp();
        chk("abort_outs", {31'd0, any_out}, 32'd0);
        nxt();
        reset = 1'b0;
        MEM_READDATA_VALID = 1'b0;
        MEM_READDATA = '0;
        smp();
        chk("abort_idle_outs", {31'd0, any_out}, 32'd0);
        nxt();
        R1_ADDR = 32'h55;
        R1_REQ = 1'b1;
        run_txn(1'b1, 1'b0, 32'h54, 32'h0, 1, 0, 0, 0, 0, 32'hD0, 1'b0);

        // R1 changes its address while held in ISSUE.
        R1_ADDR = 32'h203;
        R1_REQ = 1'b1;
        run_txn(1'b1, 1'b0, 32'h200, 32'h0, 3, 0, 1, 0, 0, 32'hE0, 1'b1);

        smp();
        chk("sb_empty", sb.size(), 32'd0);
        chk("dq_empty", dq.size(), 32'd0);
        chk("final_outs", {31'd0, any_out}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
